// File: rtl/vga_scanout_if.sv
// Pixel stream from the source into the scanout FIFO.
// Handshake: a transfer happens on a Clk edge where pix_valid && pix_ready;
// the source holds pix_data stable while pix_valid is high and pix_ready is low.
interface vga_scanout_if;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;

   modport master (output pix_data, output pix_valid, input pix_ready);
   modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator with a small pixel FIFO; all display outputs are
// registered on the Clk edge where the half-rate VGA_CLK falls.
module vga_scanout #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        Clk,
   input  logic        Reset_n,
   vga_scanout_if.slave pix,
   output logic        frame_start,
   output logic        underflow,
   input  logic        clear_underflow,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int AW      = $clog2(FIFO_DEPTH);

   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0]    h, v;
   logic [23:0]   mem [FIFO_DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          empty, full, push, pop, pix_en, visible, underflow_set;

   always_comb begin
      empty         = (wr_ptr == rd_ptr);
      full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pix_en        = VGA_CLK;
      visible       = (h < H_VIS) && (v < V_VIS);
      push          = pix.pix_valid && !full;
      pop           = pix_en && visible && !empty;
      underflow_set = pix_en && visible && empty;
   end

   assign pix.pix_ready = !full;
   assign VGA_SYNC_N    = 1'b0;

   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= pix.pix_data;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         VGA_CLK     <= 1'b0;
         h           <= '0;
         v           <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         underflow   <= 1'b0;
         frame_start <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         DrawX       <= '0;
         DrawY       <= '0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         VGA_CLK     <= ~VGA_CLK;
         frame_start <= 1'b0;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         // A starved pixel on the same edge as a clear keeps the flag set.
         if (underflow_set)        underflow <= 1'b1;
         else if (clear_underflow) underflow <= 1'b0;
         if (pix_en) begin
            frame_start <= (h == '0) && (v == '0);
            VGA_HS      <= !((h >= HS_START) && (h < HS_END));
            VGA_VS      <= !((v >= VS_START) && (v < VS_END));
            VGA_BLANK_N <= visible;
            DrawX       <= h;
            DrawY       <= v;
            {VGA_R, VGA_G, VGA_B} <= pop ? mem[rd_ptr[AW-1:0]] : 24'd0;
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 15x8 raster so whole frames
// fit in a short run; a pixel-level reference tracks expected outputs.
module tb_vga_scanout;
   localparam int HV = 8, HF = 2, HSY = 3, HB = 2;
   localparam int VV = 4, VF = 1, VSY = 2, VB = 1;
   localparam int HT = HV + HF + HSY + HB;
   localparam int VT = VV + VF + VSY + VB;
   localparam int DEPTH = 16;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic       clear_underflow = 1'b0;
   logic       frame_start, underflow;
   logic [9:0] DrawX, DrawY;
   logic [7:0] VGA_R, VGA_G, VGA_B;
   logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;

   vga_scanout_if pix_bus ();

   vga_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .pix(pix_bus),
      .frame_start(frame_start), .underflow(underflow),
      .clear_underflow(clear_underflow),
      .DrawX(DrawX), .DrawY(DrawY),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;
   int k = 0;
   int wr_n = 0;
   logic [23:0] exp_q[$];
   logic [9:0]  e_x, e_y;
   logic        e_hs, e_vs, e_bn, e_fs, e_uf;
   logic [23:0] e_rgb;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      e_x = '0; e_y = '0; e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0;
      e_fs = 1'b0; e_uf = 1'b0; e_rgb = '0; k = 0;
   endtask

   task automatic reset_dut();
      Reset_n = 1'b0;
      #2;
      model_reset();
      chk("rst_vga_clk", 32'(VGA_CLK), 32'd0);
      chk("rst_hs", 32'(VGA_HS), 32'd1);
      chk("rst_vs", 32'(VGA_VS), 32'd1);
      chk("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
      chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      chk("rst_drawx", 32'(DrawX), 32'd0);
      chk("rst_drawy", 32'(DrawY), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_pix_ready", 32'(pix_bus.pix_ready), 32'd1);
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   // Advance one Clk and update the reference from pre-edge inputs.
   task automatic step();
      int nk, p, h, v;
      bit vis, set_uf, push;
      nk = k + 1;
      push = pix_bus.pix_valid && (exp_q.size() < DEPTH);
      set_uf = 1'b0;
      e_fs = 1'b0;
      if (nk % 2 == 0) begin
         p = nk / 2 - 1;
         h = p % HT;
         v = (p / HT) % VT;
         vis = (h < HV) && (v < VV);
         e_fs = (h == 0) && (v == 0);
         e_hs = !((h >= HV + HF) && (h < HV + HF + HSY));
         e_vs = !((v >= VV + VF) && (v < VV + VF + VSY));
         e_bn = vis;
         e_x = 10'(h);
         e_y = 10'(v);
         e_rgb = '0;
         if (vis) begin
            if (exp_q.size() > 0) e_rgb = exp_q.pop_front();
            else set_uf = 1'b1;
         end
      end
      if (set_uf) e_uf = 1'b1;
      else if (clear_underflow) e_uf = 1'b0;
      if (push) exp_q.push_back(pix_bus.pix_data);
      @(posedge Clk);
      #1;
      k = nk;
   endtask

   task automatic chk_all();
      chk("vga_clk", 32'(VGA_CLK), 32'(k % 2));
      chk("hs", 32'(VGA_HS), 32'(e_hs));
      chk("vs", 32'(VGA_VS), 32'(e_vs));
      chk("blank_n", 32'(VGA_BLANK_N), 32'(e_bn));
      chk("drawx", 32'(DrawX), 32'(e_x));
      chk("drawy", 32'(DrawY), 32'(e_y));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e_rgb));
      chk("underflow", 32'(underflow), 32'(e_uf));
      chk("pix_ready", 32'(pix_bus.pix_ready), 32'(exp_q.size() < DEPTH));
      chk("sync_n", 32'(VGA_SYNC_N), 32'd0);
   endtask

   // Run until edge count reaches target; accepted writes advance pix_data.
   task automatic run_to(input int target);
      bit acc;
      while (k < target) begin
         acc = pix_bus.pix_valid && pix_bus.pix_ready;
         step();
         if (acc) begin
            wr_n++;
            pix_bus.pix_data = pix_bus.pix_data + 24'd1;
         end
         chk_all();
      end
   endtask

   initial begin
      int hs_low, vs_low, fs_cnt;
      pix_bus.pix_valid = 1'b0;
      pix_bus.pix_data  = '0;
      #1;

      // Idle source; data offered during reset must be ignored.
      pix_bus.pix_valid = 1'b1;
      pix_bus.pix_data  = 24'habcdef;
      reset_dut();
      pix_bus.pix_valid = 1'b0;
      run_to(1);
      chk("first_vga_clk_high", 32'(VGA_CLK), 32'd1);
      chk("no_fs_before_pix_en", 32'(frame_start), 32'd0);
      run_to(2);
      chk("fs_at_2nd_edge", 32'(frame_start), 32'd1);
      chk("uf_first_visible", 32'(underflow), 32'd1);
      hs_low = (VGA_HS == 1'b0) ? 1 : 0;
      vs_low = (VGA_VS == 1'b0) ? 1 : 0;
      fs_cnt = 1;
      while (k < 480) begin
         run_to(k + 1);
         if (!VGA_HS) hs_low++;
         if (!VGA_VS) vs_low++;
         if (frame_start) fs_cnt++;
      end
      chk("hs_low_clocks", 32'(hs_low), 32'd96);
      chk("vs_low_clocks", 32'(vs_low), 32'd120);
      chk("fs_pulses_2frames", 32'(fs_cnt), 32'd2);

      // Continuous incrementing stream over three frames.
      reset_dut();
      pix_bus.pix_data  = '0;
      pix_bus.pix_valid = 1'b1;
      run_to(20);
      chk("blank_rgb_h9", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      chk("blank_n_h9", 32'(VGA_BLANK_N), 32'd0);
      run_to(32);
      chk("line1_first_pixel", 32'({VGA_R, VGA_G, VGA_B}), 32'd8);
      run_to(242);
      chk("frame2_first_pixel", 32'({VGA_R, VGA_G, VGA_B}), 32'd32);
      chk("frame2_fs", 32'(frame_start), 32'd1);
      run_to(720);
      chk("stream_no_underflow", 32'(underflow), 32'd0);

      // Fill the FIFO in vertical blanking, then hold a 17th write.
      pix_bus.pix_valid = 1'b0;
      reset_dut();
      run_to(150);
      chk("uf_set_idle", 32'(underflow), 32'd1);
      clear_underflow = 1'b1;
      run_to(151);
      clear_underflow = 1'b0;
      chk("uf_cleared", 32'(underflow), 32'd0);
      run_to(200);
      pix_bus.pix_data  = 24'h000100;
      wr_n = 0;
      pix_bus.pix_valid = 1'b1;
      run_to(216);
      chk("fill_writes", 32'(wr_n), 32'd16);
      chk("ready_drop_full", 32'(pix_bus.pix_ready), 32'd0);
      run_to(241);
      chk("17th_held", 32'(wr_n), 32'd16);
      run_to(242);
      chk("first_pop_data", 32'({VGA_R, VGA_G, VGA_B}), 32'h000100);
      chk("ready_after_pop", 32'(pix_bus.pix_ready), 32'd1);
      run_to(243);
      chk("17th_accepted", 32'(wr_n), 32'd17);
      pix_bus.pix_valid = 1'b0;
      run_to(302);
      chk("17th_pop_data", 32'({VGA_R, VGA_G, VGA_B}), 32'h000110);
      chk("uf_before_drain", 32'(underflow), 32'd0);
      run_to(304);
      chk("uf_after_drain", 32'(underflow), 32'd1);
      chk("rgb_starved", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);

      // 40-pixel stall starting at the first pixel of line 1.
      reset_dut();
      pix_bus.pix_data  = '0;
      pix_bus.pix_valid = 1'b1;
      run_to(32);
      pix_bus.pix_valid = 1'b0;
      run_to(91);
      chk("uf_not_yet", 32'(underflow), 32'd0);
      run_to(92);
      chk("uf_first_starved", 32'(underflow), 32'd1);
      chk("rgb_first_starved", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      run_to(93);
      clear_underflow = 1'b1;
      run_to(94);
      clear_underflow = 1'b0;
      chk("uf_set_beats_clear", 32'(underflow), 32'd1);
      run_to(112);
      pix_bus.pix_valid = 1'b1;
      run_to(150);
      chk("uf_sticky", 32'(underflow), 32'd1);
      clear_underflow = 1'b1;
      run_to(151);
      clear_underflow = 1'b0;
      chk("uf_clear_pulse", 32'(underflow), 32'd0);
      run_to(480);

      // Reset in the middle of a visible line with the FIFO holding data.
      reset_dut();
      pix_bus.pix_data  = '0;
      pix_bus.pix_valid = 1'b1;
      run_to(72);
      chk("pre_rst_drawx", 32'(DrawX), 32'd5);
      chk("pre_rst_drawy", 32'(DrawY), 32'd2);
      run_to(73);
      pix_bus.pix_valid = 1'b0;
      reset_dut();
      run_to(2);
      chk("post_rst_fs", 32'(frame_start), 32'd1);
      chk("post_rst_drawx", 32'(DrawX), 32'd0);
      chk("post_rst_drawy", 32'(DrawY), 32'd0);
      chk("post_rst_fifo_empty", 32'(underflow), 32'd1);
      run_to(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
